// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
//   MD_WIDTH : default operand width (HI and LO are each this wide)
//   CNT_W    : iteration counter width for the default operand width
//   state_t  : sequencer states
package mult_div_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned CNT_W    = $clog2(MD_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One combinational step of unsigned restoring division.
// Ports:
//   rem_in       : partial remainder entering this step (always < divisor)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude (nonzero)
//   rem_out      : partial remainder after the trial subtraction
//   q_bit        : quotient bit produced by this step
module div_restoring_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // The shifted remainder needs one extra bit; the difference never does,
  // because whenever the subtraction is kept the result is below the divisor.
  always_comb begin
    trial   = {rem_in, dividend_bit};
    q_bit   = (trial >= {1'b0, divisor});
    diff    = trial[WIDTH-1:0] - divisor;
    rem_out = q_bit ? diff : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit with HI/LO result registers.
// Radix-2 Booth multiply and restoring divide, one step per clock.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   start_mult, start_div : one-cycle start pulses (mult has priority)
//   hi_write, lo_write    : mthi/mtlo, load HI/LO from a_in while idle
//   a_in, b_in            : operands from registers A and B
//   busy                  : operation in progress
//   done                  : one-cycle pulse when HI/LO take a result
//   div_zero              : with done, divisor was zero (HI/LO untouched)
//   hi_out, lo_out        : HI and LO registers
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned STEP_W = (WIDTH == MD_WIDTH) ? CNT_W : $clog2(WIDTH);

  state_t state;
  state_t next_state;

  logic [STEP_W-1:0] cnt;
  logic              last_step;

  // Booth registers: acc is one bit wider so the most negative multiplicand
  // cannot overflow the partial sum.
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mq;        // multiplier during mult, dividend/quotient during div
  logic             q_m1;

  // Divide registers
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             a_neg;
  logic             q_neg;
  logic             dz_flag;

  // Step results
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] mq_n;
  logic [WIDTH-1:0] rem_n;
  logic             q_bit;
  logic [WIDTH-1:0] mq_div_n;
  logic [WIDTH-1:0] quo_sgn;
  logic [WIDTH-1:0] rem_sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic busy_d;
  logic done_d;
  logic div_zero_d;

  assign last_step = (cnt == STEP_W'(WIDTH - 1));

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  assign a_mag = a_in[WIDTH-1] ? (-a_in) : a_in;
  assign b_mag = b_in[WIDTH-1] ? (-b_in) : b_in;

  // Booth step: add/subtract on {Q0, Q-1}, then arithmetic shift right.
  always_comb begin
    booth_sum = acc;
    case ({mq[0], q_m1})
      2'b01:   booth_sum = acc + mcand;
      2'b10:   booth_sum = acc - mcand;
      default: booth_sum = acc;
    endcase
    acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mq_n  = {booth_sum[0], mq[WIDTH-1:1]};
  end

  div_restoring_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_in      (rem),
    .dividend_bit(mq[WIDTH-1]),
    .divisor     (dvs),
    .rem_out     (rem_n),
    .q_bit       (q_bit)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  always_comb begin
    mq_div_n = {mq[WIDTH-2:0], q_bit};
    quo_sgn  = q_neg ? (-mq_div_n) : mq_div_n;
    rem_sgn  = a_neg ? (-rem_n) : rem_n;
  end

  // State register and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= next_state;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= div_zero_d;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_mult) begin
          next_state = MULT;
        end else if (start_div) begin
          next_state = DIV;
        end
      end
      MULT: begin
        if (last_step) begin
          next_state = DONE;
        end
      end
      DIV: begin
        if (dz_flag || last_step) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic, registered in the state register block
  always_comb begin
    busy_d     = (next_state == MULT) || (next_state == DIV);
    done_d     = (next_state == DONE);
    div_zero_d = (state == DIV) && dz_flag;
  end

  // Datapath: operand capture, iteration and HI/LO updates
  always_ff @(posedge clock) begin
    if (reset) begin
      hi_out  <= '0;
      lo_out  <= '0;
      acc     <= '0;
      mcand   <= '0;
      mq      <= '0;
      q_m1    <= 1'b0;
      dvs     <= '0;
      rem     <= '0;
      a_neg   <= 1'b0;
      q_neg   <= 1'b0;
      dz_flag <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mult) begin
            mcand <= {a_in[WIDTH-1], a_in};
            acc   <= '0;
            mq    <= b_in;
            q_m1  <= 1'b0;
            cnt   <= '0;
          end else if (start_div) begin
            mq      <= a_mag;
            dvs     <= b_mag;
            rem     <= '0;
            a_neg   <= a_in[WIDTH-1];
            q_neg   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            dz_flag <= (b_in == '0);
            cnt     <= '0;
          end else begin
            if (hi_write) begin
              hi_out <= a_in;
            end
            if (lo_write) begin
              lo_out <= a_in;
            end
          end
        end
        MULT: begin
          acc  <= acc_n;
          mq   <= mq_n;
          q_m1 <= mq[0];
          cnt  <= cnt + STEP_W'(1);
          if (last_step) begin
            hi_out <= acc_n[WIDTH-1:0];
            lo_out <= mq_n;
          end
        end
        DIV: begin
          if (!dz_flag) begin
            rem <= rem_n;
            mq  <= mq_div_n;
            cnt <= cnt + STEP_W'(1);
            if (last_step) begin
              hi_out <= rem_sgn;
              lo_out <= quo_sgn;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero,
// a separate monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] hi_m   = '0;
  logic [31:0] lo_m   = '0;
  vec_t        vecs[10];

  mult_div_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start_mult(start_mult),
    .start_div (start_div),
    .hi_write  (hi_write),
    .lo_write  (lo_write),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Issue one operation and follow it to done. inj >= 0 pulses start_div and
  // lo_write that many cycles into the operation, which must be ignored.
  task automatic run_op(input int id, input bit sm, input bit sd, input bit hw,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit edz, input int elat, input int inj);
    exp_t e;
    int   lat;
    bit   hold_ok;
    e.hi = eh;
    e.lo = el;
    e.dz = edz;
    exp_q.push_back(e);
    a_in       = a;
    b_in       = b;
    start_mult = sm;
    start_div  = sd;
    hi_write   = hw;
    tick();
    start_mult = 1'b0;
    start_div  = 1'b0;
    hi_write   = 1'b0;
    lat        = 0;
    hold_ok    = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (hi_out !== hi_m || lo_out !== lo_m || busy !== 1'b1) hold_ok = 1'b0;
      if (lat == inj) begin
        start_div = 1'b1;
        lo_write  = 1'b1;
        a_in      = 32'hDEADBEEF;
      end else begin
        start_div = 1'b0;
        lo_write  = 1'b0;
      end
      tick();
      lat++;
    end
    start_div = 1'b0;
    lo_write  = 1'b0;
    check($sformatf("v%0d latency", id), 64'(lat), 64'(elat));
    check($sformatf("v%0d busy_hold", id), 64'(hold_ok), 64'd1);
    check($sformatf("v%0d busy_at_done", id), 64'(busy), 64'd0);
    hi_m = eh;
    lo_m = el;
    tick();
    check($sformatf("v%0d done_one_cycle", id), 64'({done, busy}), 64'd0);
  endtask

  // Monitor: every done pulse consumes one expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no result", hi_out, lo_out);
        end else begin
          e = exp_q.pop_front();
          check("result_hi", 64'(hi_out), 64'(e.hi));
          check("result_lo", 64'(lo_out), 64'(e.lo));
          check("result_div_zero", 64'(div_zero), 64'(e.dz));
        end
      end else if (div_zero === 1'b1) begin
        n_cmp++;
        n_fail++;
        $display("FAIL div_zero_without_done: got div_zero=1 done=0, expected div_zero=0");
      end
    end
  end

  initial begin
    bit saw_done;
    vecs[0] = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2] = '{1'b0, 32'h7FFFFFFF,  32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[3] = '{1'b0, 32'h80000000,  32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[5] = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6] = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7] = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8] = '{1'b1, 32'd100,       32'd7,        32'd2,        32'd14};
    vecs[9] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};

    reset      = 1'b1;
    start_mult = 1'b0;
    start_div  = 1'b0;
    hi_write   = 1'b0;
    lo_write   = 1'b0;
    a_in       = '0;
    b_in       = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_div_zero", 64'(div_zero), 64'd0);
    check("reset_hi", 64'(hi_out), 64'd0);
    check("reset_lo", 64'(lo_out), 64'd0);

    foreach (vecs[i]) begin
      run_op(i, !vecs[i].is_div, vecs[i].is_div, 1'b0, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, 1'b0, 32, -1);
    end

    // mthi / mtlo, then divide by zero leaves them intact
    a_in     = 32'h12345678;
    hi_write = 1'b1;
    lo_write = 1'b1;
    tick();
    hi_write = 1'b0;
    lo_write = 1'b0;
    check("mthi", 64'(hi_out), 64'h12345678);
    check("mtlo", 64'(lo_out), 64'h12345678);
    check("mthi_no_done", 64'(done), 64'd0);
    hi_m = 32'h12345678;
    lo_m = 32'h12345678;
    run_op(10, 1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 32'h12345678, 32'h12345678, 1'b1, 1, -1);

    // Both starts plus mthi together: multiply wins, write is dropped
    run_op(11, 1'b1, 1'b1, 1'b1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 32, -1);

    // start_div and mtlo while multiplying are ignored
    run_op(12, 1'b1, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 32, 10);

    // Reset in the middle of a divide abandons it
    a_in      = 32'd100;
    b_in      = 32'd7;
    start_div = 1'b1;
    tick();
    start_div = 1'b0;
    repeat (15) tick();
    check("mid_div_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi_out), 64'd0);
    check("abort_lo", 64'(lo_out), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the multicycle RISC datapath. It sits directly downstream of operand registers A and B, alongside the ALU.
- Produces HI/LO results that feed new inputs of the MemtoReg write-back mux (mfhi/mflo).
- Started by a one-cycle control pulse from the cpu FSM, which waits on done before write-back.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits and the product is 2*WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start_mult  input  1  pulse: begin signed a_in*b_in
- start_div  input  1  pulse: begin signed a_in/b_in
- hi_write  input  1  mthi: HI <= a_in
- lo_write  input  1  mtlo: LO <= a_in
- a_in  input  WIDTH  operand A (register A output)
- b_in  input  WIDTH  operand B (register B output)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO updated this cycle
- div_zero  output  1  one-cycle pulse with done: divisor was zero
- hi_out  output  WIDTH  HI register
- lo_out  output  WIDTH  LO register

Behaviour:
- Clock/reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset (also mid-operation): state IDLE, hi_out=lo_out=0, busy=done=div_zero=0. An in-flight operation is abandoned.
- States: IDLE, MULT, DIV, DONE.
- IDLE, start acceptance:
  - Starts are sampled only in IDLE; start_mult has priority over start_div.
  - Edge k (start accepted): latch operands, clear the iteration counter, go to MULT or DIV, busy=1.
- IDLE, hi_write/lo_write:
  - Honoured only in IDLE when no start is asserted; HI/LO update at that edge, with no done pulse.
  - If a start is asserted in the same cycle, the start wins and the write is dropped.
- MULT: radix-2 Booth, one step per edge, WIDTH steps.
  - At edge k+WIDTH: {HI,LO} <= signed 64-bit product, state DONE, done=1, busy=0.
- DIV: restoring division on operand magnitudes, one step per edge, WIDTH steps.
  - At edge k+WIDTH: LO <= quotient truncated toward zero; HI <= remainder with the sign of the dividend.
  - State then goes to DONE, done=1.
- Divide by zero: b_in==0 at acceptance skips iteration.
  - At edge k+1: state DONE, done=1, div_zero=1, HI/LO unchanged.
- Overflow: -2^(WIDTH-1) / -1 gives LO=0x80000000, HI=0, div_zero=0 (wraps, no flag).
- DONE lasts exactly one cycle, then returns to IDLE. Starts and writes in DONE are ignored.
- Starts and writes while busy=1 are ignored; no queueing.
- hi_out/lo_out are registered and hold old values throughout busy. They change only on entry to DONE, on an mthi/mtlo write, or on reset.
- Latency, start pulse to done high: WIDTH cycles (32) for mult/div; 1 cycle for divide by zero.

Decomposition:
- Package mult_div_pkg:
  - state enum (IDLE, MULT, DIV, DONE)
  - WIDTH default constant
  - CNT_W = $clog2(WIDTH)
- Sub-module div_restoring_step: combinational single step.
  - Inputs: partial remainder, dividend bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
- Booth step, sign fix-up and FSM stay in the top.

Test Plan:
- start_mult, a=7, b=0xFFFFFFFD (-3) -> done exactly 32 cycles later; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high for those 32 cycles.
- start_mult, a=b=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
- start_div, a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1); a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_zero=0.
- hi_write/lo_write with a=0x12345678, then start_div with a=5, b=0 -> done and div_zero high 1 cycle after start; hi_out/lo_out still 0x12345678.
- start_div pulsed 10 cycles into a mult (5*6) -> ignored; only mult result lo_out=30, hi_out=0; lo_write during busy has no effect.
- reset pulsed 15 cycles into a div -> next cycle busy=0, hi_out=lo_out=0, and no done pulse follows.
